// File: rtl/univ_shift_reg_burst.sv
// rtl/univ_shift_reg_burst.sv - universal shift register with autonomous burst engine
// Immediate single steps in IDLE, or a latched operation repeated cnt times in RUN.
module univ_shift_reg_burst #(
    parameter int             DW      = 8,
    parameter int             CW      = 4,
    parameter logic [DW-1:0]  RST_VAL = '0
) (
    input  logic          clk,
    input  logic          async_rst_n,
    input  logic          en,
    input  logic [2:0]    mode,
    input  logic [DW-1:0] data,
    input  logic          data_l,
    input  logic          data_h,
    input  logic [CW-1:0] cnt,
    input  logic          start,
    output logic [DW-1:0] q,
    output logic          ser_out_l,
    output logic          ser_out_h,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [DW-1:0] r_q;
    logic [DW-1:0] w_q_nxt;
    logic [2:0]    r_op;
    logic [2:0]    w_op_nxt;
    logic [CW-1:0] r_rem;
    logic [CW-1:0] w_rem_nxt;

    function automatic logic [DW-1:0] f_step(
        input logic [2:0]    op,
        input logic [DW-1:0] cur,
        input logic [DW-1:0] ld,
        input logic          sl,
        input logic          sh
    );
        logic [DW-1:0] res;
        res = cur;
        case (op)
            3'b000:  res = cur;
            3'b001:  res = ld;
            3'b010:  res = {cur[DW-2:0], sl};
            3'b011:  res = {sh, cur[DW-1:1]};
            3'b100:  res = {cur[DW-2:0], cur[DW-1]};
            3'b101:  res = {cur[0], cur[DW-1:1]};
            3'b110:  res = {cur[DW-1], cur[DW-1:1]};
            default: res = '0;
        endcase
        return res;
    endfunction

    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            r_state <= S_IDLE;
            r_q     <= RST_VAL;
            r_op    <= 3'b000;
            r_rem   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_q     <= w_q_nxt;
            r_op    <= w_op_nxt;
            r_rem   <= w_rem_nxt;
        end
    end

    // start wins over en in IDLE; all control inputs are ignored outside IDLE
    always_comb begin
        w_state_nxt = r_state;
        w_q_nxt     = r_q;
        w_op_nxt    = r_op;
        w_rem_nxt   = r_rem;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_op_nxt    = mode;
                    w_rem_nxt   = cnt;
                    w_state_nxt = (cnt == '0) ? S_DONE : S_RUN;
                end else if (en) begin
                    w_q_nxt = f_step(mode, r_q, data, data_l, data_h);
                end
            end
            S_RUN: begin
                w_q_nxt   = f_step(r_op, r_q, data, data_l, data_h);
                w_rem_nxt = r_rem - CW'(1);
                if (r_rem == CW'(1)) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign q         = r_q;
    assign ser_out_l = r_q[DW-1];
    assign ser_out_h = r_q[0];
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);

endmodule

// File: tb/tb_univ_shift_reg_burst.sv
// tb/tb_univ_shift_reg_burst.sv - directed bench with per-cycle reference model for univ_shift_reg_burst
module tb_univ_shift_reg_burst;

    logic       clk = 1'b0;
    logic       clk_run = 1'b0;
    logic       async_rst_n = 1'b1;
    logic       en = 1'b0;
    logic [2:0] mode = 3'b000;
    logic [7:0] data = 8'h00;
    logic       data_l = 1'b0;
    logic       data_h = 1'b0;
    logic [3:0] cnt = 4'd0;
    logic       start = 1'b0;
    logic [7:0] q;
    logic       ser_out_l;
    logic       ser_out_h;
    logic       busy;
    logic       done;

    int vectors = 0;
    int errors  = 0;
    bit cmp_on  = 1'b0;

    univ_shift_reg_burst #(.DW(8), .CW(4), .RST_VAL(8'h00)) dut (
        .clk(clk), .async_rst_n(async_rst_n), .en(en), .mode(mode), .data(data),
        .data_l(data_l), .data_h(data_h), .cnt(cnt), .start(start), .q(q),
        .ser_out_l(ser_out_l), .ser_out_h(ser_out_h), .busy(busy), .done(done)
    );

    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: register value plus a count of busy cycles still owed
    logic [7:0] m_q = 8'h00;
    logic [2:0] m_op = 3'b000;
    int         m_steps = 0;
    bit         m_done = 1'b0;

    function automatic logic [7:0] apply(input logic [2:0] op, input logic [7:0] v,
                                         input logic [7:0] d, input logic dl, input logic dh);
        case (op)
            3'd0: return v;
            3'd1: return d;
            3'd2: return 8'((v << 1) | dl);
            3'd3: return 8'((v >> 1) | (dh ? 8'h80 : 8'h00));
            3'd4: return 8'((v << 1) | (v >> 7));
            3'd5: return 8'((v >> 1) | (v << 7));
            3'd6: return 8'($signed(v) >>> 1);
            default: return 8'h00;
        endcase
    endfunction

    always @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            m_q = 8'h00; m_op = 3'd0; m_steps = 0; m_done = 1'b0;
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (m_steps > 0) begin
            m_q = apply(m_op, m_q, data, data_l, data_h);
            m_steps--;
            if (m_steps == 0) m_done = 1'b1;
        end else if (start) begin
            m_op = mode;
            m_steps = int'(cnt);
            if (cnt == 4'd0) m_done = 1'b1;
        end else if (en) begin
            m_q = apply(mode, m_q, data, data_l, data_h);
        end
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            check("model_q", {24'd0, q}, {24'd0, m_q});
            check("model_ser_l", {31'd0, ser_out_l}, {31'd0, m_q[7]});
            check("model_ser_h", {31'd0, ser_out_h}, {31'd0, m_q[0]});
            check("model_busy", {31'd0, busy}, {31'd0, (m_steps > 0) || m_done});
            check("model_done", {31'd0, done}, {31'd0, m_done});
        end
    end

    task automatic drive(input logic e, input logic [2:0] m, input logic [7:0] d,
                         input logic dl, input logic dh, input logic s, input logic [3:0] c);
        @(negedge clk);
        en = e; mode = m; data = d; data_l = dl; data_h = dh; start = s; cnt = c;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0);
    endtask

    logic [7:0] q_hold;

    initial begin
        // 1: asynchronous reset with the clock stopped
        #2 async_rst_n = 1'b0;
        #1;
        check("rst_q", {24'd0, q}, 32'h00);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        #2 async_rst_n = 1'b1;
        #1 clk_run = 1'b1;
        cmp_on = 1'b1;

        // 2: immediate single steps
        drive(1'b1, 3'd1, 8'hA5, 1'b0, 1'b0, 1'b0, 4'd0); check("imm_load", {24'd0, q}, 32'hA5);
        drive(1'b1, 3'd2, 8'h00, 1'b1, 1'b0, 1'b0, 4'd0); check("imm_shl", {24'd0, q}, 32'h4B);
        drive(1'b1, 3'd3, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0); check("imm_shr", {24'd0, q}, 32'h25);
        drive(1'b1, 3'd1, 8'h81, 1'b0, 1'b0, 1'b0, 4'd0);
        drive(1'b1, 3'd4, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0); check("imm_rotl", {24'd0, q}, 32'h03);
        drive(1'b1, 3'd1, 8'h80, 1'b0, 1'b0, 1'b0, 4'd0);
        drive(1'b1, 3'd6, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0); check("imm_ashr", {24'd0, q}, 32'hC0);
        drive(1'b1, 3'd7, 8'hFF, 1'b1, 1'b1, 1'b0, 4'd0); check("imm_clear", {24'd0, q}, 32'h00);

        // 3: en low holds
        drive(1'b1, 3'd1, 8'h96, 1'b0, 1'b0, 1'b0, 4'd0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 3'd2, 8'h00, 1'b1, 1'b1, 1'b0, 4'd0);
            check("hold_q", {24'd0, q}, 32'h96);
        end

        // 4: rotr burst of 3 with noise on control inputs while busy
        drive(1'b1, 3'd1, 8'h01, 1'b0, 1'b0, 1'b0, 4'd0);
        drive(1'b0, 3'd5, 8'h00, 1'b0, 1'b0, 1'b1, 4'd3);
        check("b4_start_q", {24'd0, q}, 32'h01);
        check("b4_start_busy", {31'd0, busy}, 32'd1);
        drive(1'b1, 3'd1, 8'hFF, 1'b1, 1'b1, 1'b1, 4'd7); check("b4_step1", {24'd0, q}, 32'h80);
        drive(1'b1, 3'd7, 8'h55, 1'b0, 1'b1, 1'b1, 4'd1); check("b4_step2", {24'd0, q}, 32'h40);
        drive(1'b1, 3'd2, 8'hAA, 1'b1, 1'b0, 1'b0, 4'd2); check("b4_step3", {24'd0, q}, 32'h20);
        check("b4_done", {31'd0, done}, 32'd1);
        drive(1'b1, 3'd1, 8'hFF, 1'b0, 1'b0, 1'b1, 4'd2);
        check("b4_after_done", {31'd0, done}, 32'd0);
        check("b4_after_busy", {31'd0, busy}, 32'd0);
        check("b4_after_q", {24'd0, q}, 32'h20);

        // 5: zero-length burst
        drive(1'b0, 3'd2, 8'h00, 1'b1, 1'b0, 1'b1, 4'd0);
        check("b0_q", {24'd0, q}, 32'h20);
        check("b0_done", {31'd0, done}, 32'd1);
        check("b0_busy", {31'd0, busy}, 32'd1);
        idle();
        check("b0_end_busy", {31'd0, busy}, 32'd0);

        // 6: shl burst aborted by reset after two steps
        drive(1'b1, 3'd1, 8'hFF, 1'b0, 1'b0, 1'b0, 4'd0);
        drive(1'b0, 3'd2, 8'h00, 1'($urandom), 1'b0, 1'b1, 4'd5);
        drive(1'b0, 3'd0, 8'h00, 1'($urandom), 1'b0, 1'b0, 4'd0);
        drive(1'b0, 3'd0, 8'h00, 1'($urandom), 1'b0, 1'b0, 4'd0);
        q_hold = q;
        check("abort_pre_hi", {24'd0, q_hold & 8'hFC}, 32'hFC);
        #2 async_rst_n = 1'b0;
        #1;
        check("abort_q", {24'd0, q}, 32'h00);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        #3 async_rst_n = 1'b1;
        idle();
        check("abort_no_done", {31'd0, done}, 32'd0);
        drive(1'b1, 3'd1, 8'h3C, 1'b0, 1'b0, 1'b0, 4'd0);
        check("post_rst_load", {24'd0, q}, 32'h3C);
        idle();
        idle();

        cmp_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
